// File: rtl/bmem_arb_pkg.sv
// Shared types and defaults for the bitmap memory arbiter: FSM states,
// read-return owner tags and the default bus widths.
package bmem_arb_pkg;

    localparam int DEF_DATA_W = 1536;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_DISP = 1'b1
    } owner_e;

    // Tag travelling alongside a read so the returning mem_q can be steered.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   last;
    } rd_tag_t;

endpackage

// File: rtl/bmem_burst_gen.sv
// Display burst address generator: latches the base on start, walks the beat
// counter and flags the final beat. Address arithmetic wraps modulo 2^ADDR_W.
module bmem_burst_gen
    import bmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  beat_q, beat_d;

    // Beat 0 is issued in the grant cycle straight from base_i, so the
    // counter is loaded with 1 ready for the first BURST-state beat.
    assign addr_o = start_i ? base_i : (base_q + ADDR_W'(beat_q));
    assign last_o = start_i ? (BURST_LEN == 1) : (beat_q == LAST_BEAT);

    always_comb begin
        base_d = base_q;
        beat_d = beat_q;
        if (start_i) begin
            base_d = base_i;
            beat_d = (BURST_LEN > 1) ? CNT_W'(1) : '0;
        end else if (advance_i) begin
            beat_d = last_o ? '0 : (beat_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates the bitmap memory between CPU ldb/stb and display bursts.
// Optional statistics outputs are enabled with BMEM_ARB_STATS_EN.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic              disp_last,
    output logic [DATA_W-1:0] disp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
`ifdef BMEM_ARB_STATS_EN
    output logic [31:0]       stat_cpu_stalls,
    output logic [31:0]       stat_disp_bursts,
    output logic [7:0]        stat_max_wait,
`endif
    input  logic [DATA_W-1:0] mem_q
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fair_q, fair_d;
    rd_tag_t           tag_q, tag_d;
    logic [DATA_W-1:0] cpu_hold_q, disp_hold_q;

    logic              cpu_gnt;
    logic              disp_issue;
    logic              burst_adv;
    logic              burst_last;
    logic [ADDR_W-1:0] burst_addr;

    bmem_burst_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (disp_gnt),
        .advance_i (burst_adv),
        .base_i    (disp_addr),
        .addr_o    (burst_addr),
        .last_o    (burst_last)
    );

    // Grant decode. A starved display preempts the CPU, except right after a
    // burst when the CPU is owed one slot (fair_q).
    always_comb begin
        cpu_gnt    = 1'b0;
        disp_gnt   = 1'b0;
        disp_issue = 1'b0;
        burst_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !(disp_req && (wait_q == WAIT_MAX) && !fair_q)) begin
                    cpu_gnt = 1'b1;
                end else if (disp_req) begin
                    disp_gnt   = 1'b1;
                    disp_issue = 1'b1;
                end
            end
            ST_BURST: begin
                disp_issue = 1'b1;
                burst_adv  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fair_d  = fair_q;
        case (state_q)
            ST_IDLE:  if (disp_gnt && (BURST_LEN > 1)) state_d = ST_BURST;
            ST_BURST: if (burst_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (disp_gnt) begin
            wait_d = '0;
        end else if (disp_req && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        if (cpu_gnt) begin
            fair_d = 1'b0;
        end else if (disp_issue && burst_last) begin
            fair_d = 1'b1;
        end

        tag_d.valid = (cpu_gnt && !cpu_we) || disp_issue;
        tag_d.owner = disp_issue ? OWN_DISP : OWN_CPU;
        tag_d.last  = disp_issue && burst_last;
    end

    assign mem_addr  = cpu_gnt ? cpu_addr : (disp_issue ? burst_addr : '0);
    assign mem_wren  = cpu_req && cpu_we && cpu_gnt;
    assign mem_data  = cpu_wdata;
    assign cpu_stall = cpu_req && !cpu_gnt;

    assign cpu_rvalid  = tag_q.valid && (tag_q.owner == OWN_CPU);
    assign disp_rvalid = tag_q.valid && (tag_q.owner == OWN_DISP);
    assign disp_last   = disp_rvalid && tag_q.last;
    assign cpu_rdata   = cpu_rvalid  ? mem_q : cpu_hold_q;
    assign disp_rdata  = disp_rvalid ? mem_q : disp_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            fair_q      <= 1'b0;
            tag_q       <= '0;
            cpu_hold_q  <= '0;
            disp_hold_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fair_q  <= fair_d;
            tag_q   <= tag_d;
            if (cpu_rvalid)  cpu_hold_q  <= mem_q;
            if (disp_rvalid) disp_hold_q <= mem_q;
        end
    end

`ifdef BMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_stalls  <= '0;
            stat_disp_bursts <= '0;
            stat_max_wait    <= '0;
        end else begin
            if (cpu_stall) stat_cpu_stalls  <= stat_cpu_stalls + 32'd1;
            if (disp_gnt)  stat_disp_bursts <= stat_disp_bursts + 32'd1;
            if (8'(wait_q) > stat_max_wait) stat_max_wait <= 8'(wait_q);
        end
    end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: default instance plus a MAX_WAIT=2
// instance that exposes the one-CPU-slot-between-bursts behaviour.
module tb_bmem_arbiter;

    localparam int DW = 1536;
    localparam int AW = 16;
    typedef logic [DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, disp_req;
    logic [AW-1:0] cpu_addr, disp_addr;
    word_t         cpu_wdata;
    word_t         mem_q = '0;
    word_t         zero_q = '0;

    logic          cpu_stall, cpu_rvalid, disp_gnt, disp_rvalid, disp_last, mem_wren;
    word_t         cpu_rdata, disp_rdata, mem_data;
    logic [AW-1:0] mem_addr;

    logic          f_cpu_req, f_disp_req;
    logic          f_cpu_stall, f_cpu_rvalid, f_disp_gnt, f_disp_rvalid, f_disp_last, f_mem_wren;
    word_t         f_cpu_rdata, f_disp_rdata, f_mem_data;
    logic [AW-1:0] f_mem_addr;

`ifdef BMEM_ARB_STATS_EN
    logic [31:0] s_stalls, s_bursts, fs_stalls, fs_bursts;
    logic [7:0]  s_maxw, fs_maxw;
`endif

    int n_tests = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    bmem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_last(disp_last), .disp_rdata(disp_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
`ifdef BMEM_ARB_STATS_EN
        .stat_cpu_stalls(s_stalls), .stat_disp_bursts(s_bursts), .stat_max_wait(s_maxw),
`endif
        .mem_q(mem_q)
    );

    bmem_arbiter #(.MAX_WAIT(2)) u_fair (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(f_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(f_cpu_stall), .cpu_rvalid(f_cpu_rvalid), .cpu_rdata(f_cpu_rdata),
        .disp_req(f_disp_req), .disp_addr(disp_addr), .disp_gnt(f_disp_gnt),
        .disp_rvalid(f_disp_rvalid), .disp_last(f_disp_last), .disp_rdata(f_disp_rdata),
        .mem_addr(f_mem_addr), .mem_wren(f_mem_wren), .mem_data(f_mem_data),
`ifdef BMEM_ARB_STATS_EN
        .stat_cpu_stalls(fs_stalls), .stat_disp_bursts(fs_bursts), .stat_max_wait(fs_maxw),
`endif
        .mem_q(zero_q)
    );

    // Memory model: registered read (old data on same-cycle write), unwritten
    // locations return an address-derived pattern.
    word_t mem [logic [AW-1:0]];

    function automatic word_t pat(input logic [AW-1:0] a);
        return {48{16'hC0DE, a}};
    endfunction

    always @(posedge clk) begin
        if (mem.exists(mem_addr)) mem_q <= mem[mem_addr];
        else                      mem_q <= pat(mem_addr);
        if (mem_wren) mem[mem_addr] = mem_data;
    end

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t         w1;
        logic [AW-1:0] ea;
        logic [11:0]   f_stall_pat;

        w1 = {48{32'hDEAD_0005}};
        f_stall_pat = 12'b0111_1011_1100;

        rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 0; disp_addr = '0; f_cpu_req = 0; f_disp_req = 0;

        repeat (2) tick();
        settle();
        $display("[TB] reset state");
        check_eq("rst_disp_gnt",    word_t'(disp_gnt),    word_t'(1'b0));
        check_eq("rst_cpu_rvalid",  word_t'(cpu_rvalid),  word_t'(1'b0));
        check_eq("rst_disp_rvalid", word_t'(disp_rvalid), word_t'(1'b0));
        check_eq("rst_disp_last",   word_t'(disp_last),   word_t'(1'b0));
        check_eq("rst_mem_wren",    word_t'(mem_wren),    word_t'(1'b0));
        check_eq("rst_mem_addr",    word_t'(mem_addr),    word_t'(16'h0));
        check_eq("rst_cpu_rdata",   cpu_rdata,            '0);
        tick();
        rst_n = 1'b1;

        // 1. CPU stb then ldb at address 5
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_wdata = w1;
        settle();
        $display("[TB] cpu stb addr 0005");
        check_eq("t1_stb_stall", word_t'(cpu_stall), word_t'(1'b0));
        check_eq("t1_stb_wren",  word_t'(mem_wren),  word_t'(1'b1));
        check_eq("t1_stb_addr",  word_t'(mem_addr),  word_t'(16'h0005));
        check_eq("t1_stb_data",  mem_data,           w1);
        tick();
        cpu_we = 0;
        settle();
        $display("[TB] cpu ldb addr 0005");
        check_eq("t1_ldb_stall",  word_t'(cpu_stall),  word_t'(1'b0));
        check_eq("t1_ldb_wren",   word_t'(mem_wren),   word_t'(1'b0));
        check_eq("t1_ldb_rvalid0", word_t'(cpu_rvalid), word_t'(1'b0));
        tick();
        cpu_req = 0;
        settle();
        check_eq("t1_rvalid", word_t'(cpu_rvalid), word_t'(1'b1));
        check_eq("t1_rdata",  cpu_rdata,           w1);
        check_eq("t1_no_disp_rvalid", word_t'(disp_rvalid), word_t'(1'b0));
        tick();
        settle();
        check_eq("t1_rvalid_drop", word_t'(cpu_rvalid), word_t'(1'b0));
        check_eq("t1_rdata_hold",  cpu_rdata,           w1);

        // 2. Display-only burst at 0x0010
        tick();
        disp_req = 1; disp_addr = 16'h0010;
        settle();
        $display("[TB] disp burst base 0010");
        check_eq("t2_gnt",   word_t'(disp_gnt), word_t'(1'b1));
        check_eq("t2_addr0", word_t'(mem_addr), word_t'(16'h0010));
        for (int b = 1; b <= 4; b++) begin
            tick();
            disp_req = 0;
            settle();
            ea = (b < 4) ? 16'h0010 + 16'(b) : 16'h0000;
            check_eq($sformatf("t2_gnt_off%0d", b), word_t'(disp_gnt),    word_t'(1'b0));
            check_eq($sformatf("t2_addr%0d", b),    word_t'(mem_addr),    word_t'(ea));
            check_eq($sformatf("t2_rvalid%0d", b),  word_t'(disp_rvalid), word_t'(1'b1));
            check_eq($sformatf("t2_rdata%0d", b),   disp_rdata,           pat(16'h0010 + 16'(b - 1)));
            check_eq($sformatf("t2_last%0d", b),    word_t'(disp_last),   word_t'(b == 4));
        end
        tick();
        settle();
        check_eq("t2_rvalid_end", word_t'(disp_rvalid), word_t'(1'b0));

        // 3. CPU held plus display request: display starves for exactly 8 cycles
        $display("[TB] cpu held with disp_req, starvation bound");
        for (int c = 0; c <= 12; c++) begin
            tick();
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0007;
            disp_req = (c <= 8); disp_addr = 16'h0040;
            settle();
            check_eq($sformatf("t3_stall_c%0d", c), word_t'(cpu_stall), word_t'(c >= 8 && c <= 11));
            check_eq($sformatf("t3_gnt_c%0d", c),   word_t'(disp_gnt),  word_t'(c == 8));
        end

        // 4. Address wrap from 0xFFFE
        tick();
        cpu_req = 0; disp_req = 1; disp_addr = 16'hFFFE;
        settle();
        $display("[TB] disp burst base FFFE");
        check_eq("t4_gnt",   word_t'(disp_gnt), word_t'(1'b1));
        check_eq("t4_addr0", word_t'(mem_addr), word_t'(16'hFFFE));
        for (int b = 1; b <= 3; b++) begin
            tick();
            disp_req = 0;
            settle();
            ea = 16'hFFFE + 16'(b);
            check_eq($sformatf("t4_addr%0d", b), word_t'(mem_addr), word_t'(ea));
        end
        tick();
        settle();
        check_eq("t4_last",  word_t'(disp_last), word_t'(1'b1));
        check_eq("t4_rdata", disp_rdata,         pat(16'h0001));

        // 5. MAX_WAIT=2 instance: bursts back to back, one CPU slot between them
        $display("[TB] fairness: back-to-back bursts with cpu pending");
        for (int c = 0; c <= 11; c++) begin
            tick();
            f_cpu_req = 1; f_disp_req = 1;
            settle();
            check_eq($sformatf("t5_stall_c%0d", c), word_t'(f_cpu_stall), word_t'(f_stall_pat[c]));
            check_eq($sformatf("t5_gnt_c%0d", c),   word_t'(f_disp_gnt),  word_t'(c == 2 || c == 7));
        end
        tick();
        f_cpu_req = 0; f_disp_req = 0;

        // 6. Reset during beat 2
        tick();
        disp_req = 1; disp_addr = 16'h0020;
        settle();
        $display("[TB] disp burst base 0020, reset at beat 2");
        check_eq("t6_gnt", word_t'(disp_gnt), word_t'(1'b1));
        tick();
        disp_req = 0;
        tick();
        settle();
        check_eq("t6_beat2_addr",   word_t'(mem_addr),    word_t'(16'h0022));
        check_eq("t6_beat2_rvalid", word_t'(disp_rvalid), word_t'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_disp_rvalid", word_t'(disp_rvalid), word_t'(1'b0));
        check_eq("t6_rst_disp_last",   word_t'(disp_last),   word_t'(1'b0));
        check_eq("t6_rst_cpu_rvalid",  word_t'(cpu_rvalid),  word_t'(1'b0));
        check_eq("t6_rst_mem_addr",    word_t'(mem_addr),    word_t'(16'h0));
        check_eq("t6_rst_cpu_rdata",   cpu_rdata,            '0);
        check_eq("t6_rst_disp_rdata",  disp_rdata,           '0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq($sformatf("t6_post_rvalid%0d", c), word_t'(disp_rvalid), word_t'(1'b0));
            check_eq($sformatf("t6_post_addr%0d", c),   word_t'(mem_addr),    word_t'(16'h0));
            tick();
        end
        disp_req = 1; disp_addr = 16'h0030;
        settle();
        $display("[TB] disp burst base 0030 after reset");
        check_eq("t6_regnt",      word_t'(disp_gnt), word_t'(1'b1));
        check_eq("t6_regnt_addr", word_t'(mem_addr), word_t'(16'h0030));
        tick();
        disp_req = 0;
        settle();
        check_eq("t6_re_addr1", word_t'(mem_addr), word_t'(16'h0031));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
